edge_stream_filter: RTL and testbench

Parametrised streaming 3×3 Sobel edge filter, the successor to the fixed-width, fixed-line-length edge detector in the video path. It accepts one RGB pixel per valid cycle with explicit start-of-frame and end-of-line markers. It converts each pixel to grayscale, buffers two lines internally and emits one result per input pixel after a fixed latency. It adds a runtime-selectable output mode, a programmable threshold, short-line support and explicit border masking.

---
 rtl/edge_stream_filter_pkg.sv | 32 +++
 rtl/edge_stream_filter_line_window.sv | 120 ++++++++++++
 rtl/edge_stream_filter.sv | 171 +++++++++++++++++
 tb/tb_edge_stream_filter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_stream_filter_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the streaming Sobel edge filter:
//   - output mode encodings
//   - gray conversion coefficients (weights sum to 256, so the >>8 keeps the
//     result inside PIX_W bits)
//   - end-to-end pipeline latency
//   - row-counter helper used by the line window
// ---------------------------------------------------------------------------
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'd0,
        MODE_MAG  = 2'd1,
        MODE_BIN  = 2'd2,
        MODE_INV  = 2'd3
    } mode_e;

    localparam int GRAY_CR    = 77;
    localparam int GRAY_CG    = 150;
    localparam int GRAY_CB    = 29;
    localparam int GRAY_SHIFT = 8;

    localparam int EDGE_LAT   = 4;

    // Rows beyond the second are all equivalent for masking purposes, so the
    // row index stops at 2.
    function automatic logic [1:0] row_advance(input logic [1:0] r);
        return (r == 2'd2) ? 2'd2 : r + 2'd1;
    endfunction

endpackage

// File: rtl/edge_stream_filter_line_window.sv
// ---------------------------------------------------------------------------
// line_window
// Two-line buffer plus 3x3 sliding window for the Sobel filter.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   in_valid             gray sample qualifier
//   in_gray [PIX_W]      gray sample
//   in_sof, in_eol       frame start / line end markers (qualified by in_valid)
//   win_valid            window updated this cycle (in_valid delayed by one)
//   win_taps [9*PIX_W]   taps, tap (row i, col j) at bits (i*3+j)*PIX_W;
//                        row 0 is the oldest line, col 2 the newest column
//   mask_mag             window not fully inside the frame (r<2 or c<2)
//   mask_gray            window centre outside the frame (r<1 or c<1)
// ---------------------------------------------------------------------------
module line_window
    import edge_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int COLS  = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   in_gray,
    input  logic               in_sof,
    input  logic               in_eol,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win_taps,
    output logic               mask_mag,
    output logic               mask_gray
);

    localparam int               COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    // Position of the next valid sample
    logic [COL_W-1:0] col_cnt;
    logic [1:0]       row_cnt;

    // Position of the sample currently presented (sof overrides the counters)
    logic [COL_W-1:0] cur_c;
    logic [1:0]       cur_r;

    // line_a holds the previous line, line_b the line before it
    logic [PIX_W-1:0] line_a [COLS];
    logic [PIX_W-1:0] line_b [COLS];
    logic [PIX_W-1:0] rd_a;
    logic [PIX_W-1:0] rd_b;

    logic [PIX_W-1:0] win_p2 [3][3];

    always_comb begin
        cur_c = in_sof ? '0 : col_cnt;
        cur_r = in_sof ? 2'd0 : row_cnt;
        rd_a  = line_a[cur_c];
        rd_b  = line_b[cur_c];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_cnt <= '0;
            row_cnt <= 2'd0;
        end else if (in_valid) begin
            // A line also ends when it reaches the buffer depth.
            if (in_eol || (cur_c == COL_LAST)) begin
                col_cnt <= '0;
                row_cnt <= row_advance(cur_r);
            end else begin
                col_cnt <= cur_c + 1'b1;
                row_cnt <= cur_r;
            end
        end
    end

    // Read-before-write: the old column value moves down one line while the
    // new sample takes its place. Contents outside the current frame are only
    // ever read under a mask, so the buffers carry no reset.
    always_ff @(posedge clock) begin
        if (in_valid) begin
            line_a[cur_c] <= in_gray;
            line_b[cur_c] <= rd_a;
        end
    end

    // ---- S2: window shift ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_p2[i][j] <= '0;
                end
            end
            win_valid <= 1'b0;
            mask_mag  <= 1'b1;
            mask_gray <= 1'b1;
        end else begin
            win_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 3; i++) begin
                    win_p2[i][0] <= win_p2[i][1];
                    win_p2[i][1] <= win_p2[i][2];
                end
                win_p2[0][2] <= rd_b;
                win_p2[1][2] <= rd_a;
                win_p2[2][2] <= in_gray;
                mask_mag     <= (cur_r < 2'd2) || (cur_c < COL_TWO);
                mask_gray    <= (cur_r == 2'd0) || (cur_c == '0);
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            assign win_taps[(gi*3+gj)*PIX_W +: PIX_W] = win_p2[gi][gj];
        end
    end

endmodule

// File: rtl/edge_stream_filter.sv
// ---------------------------------------------------------------------------
// edge_stream_filter
// Streaming 3x3 Sobel edge filter, one RGB pixel in and one result out per
// valid cycle, fixed latency of EDGE_LAT cycles.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   pix_valid             input qualifier (no backpressure)
//   pix_rgb [3*PIX_W]     {R,G,B}
//   pix_sof, pix_eol      first pixel of frame / last pixel of line
//   mode [2]              0 gray, 1 magnitude, 2 binary threshold, 3 inverted
//   threshold [PIX_W]     edge compare level
//   out_valid             result qualifier
//   out_rgb [3*PIX_W]     {v,v,v} with v the selected result
//   out_edge              magnitude >= threshold
// ---------------------------------------------------------------------------
module edge_stream_filter
    import edge_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int COLS  = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [3*PIX_W-1:0] pix_rgb,
    input  logic               pix_sof,
    input  logic               pix_eol,
    input  logic [1:0]         mode,
    input  logic [PIX_W-1:0]   threshold,
    output logic               out_valid,
    output logic [3*PIX_W-1:0] out_rgb,
    output logic               out_edge
);

    localparam int GRAY_W = PIX_W + 8;
    localparam int SOB_W  = PIX_W + 3;

    function automatic logic [PIX_W-1:0] rgb_to_gray(input logic [3*PIX_W-1:0] rgb);
        logic [GRAY_W-1:0] acc;
        acc = GRAY_W'(GRAY_CR) * GRAY_W'(rgb[3*PIX_W-1 -: PIX_W])
            + GRAY_W'(GRAY_CG) * GRAY_W'(rgb[2*PIX_W-1 -: PIX_W])
            + GRAY_W'(GRAY_CB) * GRAY_W'(rgb[PIX_W-1:0]);
        return acc[GRAY_SHIFT +: PIX_W];
    endfunction

    function automatic logic signed [SOB_W-1:0] tap_s(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // |G| never reaches -2^(SOB_W-1), so negation cannot overflow.
    function automatic logic [SOB_W-1:0] abs_s(input logic signed [SOB_W-1:0] v);
        return v[SOB_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_mag(input logic [SOB_W-1:0] s);
        return (|s[SOB_W-1:PIX_W]) ? {PIX_W{1'b1}} : s[PIX_W-1:0];
    endfunction

    logic                      vld_p1;
    logic [PIX_W-1:0]          gray_p1;
    logic                      sof_p1;
    logic                      eol_p1;

    logic                      vld_p2;
    logic [9*PIX_W-1:0]        taps_p2;
    logic                      mask_mag_p2;
    logic                      mask_gray_p2;
    logic signed [SOB_W-1:0]   t [3][3];
    logic signed [SOB_W-1:0]   gx_c;
    logic signed [SOB_W-1:0]   gy_c;

    logic                      vld_p3;
    logic signed [SOB_W-1:0]   gx_p3;
    logic signed [SOB_W-1:0]   gy_p3;
    logic [PIX_W-1:0]          gray_p3;
    logic                      mask_mag_p3;

    logic [PIX_W-1:0]          mag_c;
    logic                      edge_c;
    logic [PIX_W-1:0]          res_c;

    // ---- S1: gray conversion ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid;
        end
    end

    always_ff @(posedge clock) begin
        gray_p1 <= rgb_to_gray(pix_rgb);
        sof_p1  <= pix_sof;
        eol_p1  <= pix_eol;
    end

    // ---- S2: line buffers and window ----
    line_window #(
        .PIX_W (PIX_W),
        .COLS  (COLS)
    ) u_window (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (vld_p1),
        .in_gray   (gray_p1),
        .in_sof    (sof_p1),
        .in_eol    (eol_p1),
        .win_valid (vld_p2),
        .win_taps  (taps_p2),
        .mask_mag  (mask_mag_p2),
        .mask_gray (mask_gray_p2)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_tr
        for (genvar gj = 0; gj < 3; gj++) begin : g_tc
            assign t[gi][gj] = tap_s(taps_p2[(gi*3+gj)*PIX_W +: PIX_W]);
        end
    end

    // Gx: right column minus left column; Gy: newest row minus oldest row.
    assign gx_c = (t[0][2] + (t[1][2] <<< 1) + t[2][2])
                - (t[0][0] + (t[1][0] <<< 1) + t[2][0]);
    assign gy_c = (t[2][0] + (t[2][1] <<< 1) + t[2][2])
                - (t[0][0] + (t[0][1] <<< 1) + t[0][2]);

    // ---- S3: gradient register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p3 <= 1'b0;
        end else begin
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clock) begin
        gx_p3       <= gx_c;
        gy_p3       <= gy_c;
        mask_mag_p3 <= mask_mag_p2;
        gray_p3     <= mask_gray_p2 ? '0 : taps_p2[4*PIX_W +: PIX_W];
    end

    // ---- S4: magnitude, mode mux, output register ----
    always_comb begin
        mag_c  = mask_mag_p3 ? '0 : sat_mag(abs_s(gx_p3) + abs_s(gy_p3));
        edge_c = (mag_c >= threshold);
        res_c  = gray_p3;
        case (mode_e'(mode))
            MODE_GRAY: res_c = gray_p3;
            MODE_MAG:  res_c = mag_c;
            MODE_BIN:  res_c = edge_c ? {PIX_W{1'b1}} : '0;
            MODE_INV:  res_c = ~mag_c;
            default:   res_c = gray_p3;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_rgb   <= '0;
            out_edge  <= 1'b0;
        end else begin
            out_valid <= vld_p3;
            if (vld_p3) begin
                out_rgb  <= {3{res_c}};
                out_edge <= edge_c;
            end
        end
    end

endmodule

// File: tb/tb_edge_stream_filter.sv
// ---------------------------------------------------------------------------
// tb_edge_stream_filter
// Directed and randomized frames for edge_stream_filter (COLS=16). A frame
// model keeps every gray sample at its (row, col) image position and derives
// each expected result from the Sobel rules directly.
// ---------------------------------------------------------------------------
module tb_edge_stream_filter;

    localparam int PIX_W = 8;
    localparam int COLS  = 16;
    localparam int MAXR  = 64;
    localparam int LAT   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic [1:0]  mode = 2'd1;
    logic [7:0]  threshold = 8'd1;
    logic        out_valid;
    logic [23:0] out_rgb;
    logic        out_edge;

    edge_stream_filter #(
        .PIX_W (PIX_W),
        .COLS  (COLS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_rgb   (pix_rgb),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .mode      (mode),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_rgb   (out_rgb),
        .out_edge  (out_edge)
    );

    always #5 clock = ~clock;

    typedef struct {
        int mag;
        int gray;
    } exp_t;

    exp_t        exp_q[$];
    int          img [MAXR][COLS];
    int          m_r = 0;
    int          m_c = 0;
    bit          vh [LAT];
    int          checks = 0;
    int          failures = 0;
    logic [23:0] cnt_target = '0;
    int          cnt_hits = 0;

    // Frame model: place the pixel, derive its expected result, advance.
    task automatic model_push(input logic [23:0] rgb, input bit sof, input bit eol);
        int g, gx, gy, mag, gc;
        exp_t e;
        if (sof) begin
            m_r = 0;
            m_c = 0;
            for (int i = 0; i < MAXR; i++)
                for (int j = 0; j < COLS; j++)
                    img[i][j] = 0;
        end
        g = (77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0])) / 256;
        img[m_r][m_c] = g;
        mag = 0;
        if (m_r >= 2 && m_c >= 2) begin
            gx = (img[m_r-2][m_c] + 2*img[m_r-1][m_c] + img[m_r][m_c])
               - (img[m_r-2][m_c-2] + 2*img[m_r-1][m_c-2] + img[m_r][m_c-2]);
            gy = (img[m_r][m_c-2] + 2*img[m_r][m_c-1] + img[m_r][m_c])
               - (img[m_r-2][m_c-2] + 2*img[m_r-2][m_c-1] + img[m_r-2][m_c]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (mag > 255) mag = 255;
        end
        gc = (m_r >= 1 && m_c >= 1) ? img[m_r-1][m_c-1] : 0;
        e.mag  = mag;
        e.gray = gc;
        exp_q.push_back(e);
        if (eol || m_c == COLS-1) begin
            if (m_r < MAXR-1) m_r++;
            m_c = 0;
        end else begin
            m_c++;
        end
    endtask

    task automatic step(input bit v, input logic [23:0] rgb, input bit sof, input bit eol);
        exp_t        e;
        int          ev;
        logic [23:0] exp_rgb;
        logic        exp_edge;
        pix_valid = v;
        pix_rgb   = rgb;
        pix_sof   = sof;
        pix_eol   = eol;
        if (v) model_push(rgb, sof, eol);
        @(posedge clock);
        #1;
        for (int i = LAT-1; i > 0; i--) vh[i] = vh[i-1];
        vh[0] = v;
        checks++;
        assert (out_valid === vh[LAT-1]) else begin
            failures++;
            $error("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, vh[LAT-1], $time);
        end
        if (out_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL extra_output got=%h exp=none t=%0t", out_rgb, $time);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                case (mode)
                    2'd0:    ev = e.gray;
                    2'd1:    ev = e.mag;
                    2'd2:    ev = (e.mag >= int'(threshold)) ? 255 : 0;
                    default: ev = 255 - e.mag;
                endcase
                exp_rgb  = {3{ev[7:0]}};
                exp_edge = (e.mag >= int'(threshold));
                checks++;
                assert (out_rgb === exp_rgb) else begin
                    failures++;
                    $error("FAIL out_rgb got=%h exp=%h mode=%0d t=%0t", out_rgb, exp_rgb, mode, $time);
                end
                checks++;
                assert (out_edge === exp_edge) else begin
                    failures++;
                    $error("FAIL out_edge got=%0b exp=%0b t=%0t", out_edge, exp_edge, $time);
                end
                if (out_rgb === cnt_target) cnt_hits++;
            end
        end
    endtask

    // Idle cycle with junk on the unqualified inputs.
    task automatic idle();
        step(1'b0, 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    function automatic logic [23:0] pat_rgb(input int pat, input int c);
        case (pat)
            0:       return 24'h646464;
            1:       return (c >= 4) ? 24'hFFFFFF : 24'h000000;
            3:       return 24'hFF0000;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic send_frame(input int rows, input int cols, input int pat,
                              input bit gaps, input bit use_eol, input int limit);
        int n;
        n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (limit >= 0 && n >= limit) return;
                if (gaps && $urandom_range(0, 3) == 0) idle();
                step(1'b1, pat_rgb(pat, c), (r == 0 && c == 0), use_eol && (c == cols-1));
                n++;
            end
        end
    endtask

    task automatic drain();
        repeat (LAT + 2) idle();
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic expect_count(input string tag, input int exp_n);
        checks++;
        assert (cnt_hits == exp_n) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, cnt_hits, exp_n);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        assert (out_valid === 1'b0) else begin
            failures++;
            $error("FAIL %s_valid got=%0b exp=0", tag, out_valid);
        end
        checks++;
        assert (out_rgb === 24'h0) else begin
            failures++;
            $error("FAIL %s_rgb got=%h exp=000000", tag, out_rgb);
        end
        checks++;
        assert (out_edge === 1'b0) else begin
            failures++;
            $error("FAIL %s_edge got=%0b exp=0", tag, out_edge);
        end
    endtask

    task automatic async_reset_mid();
        pix_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        exp_q.delete();
        for (int i = 0; i < LAT; i++) vh[i] = 1'b0;
        m_r = 0;
        m_c = 0;
        @(posedge clock);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < LAT; i++) vh[i] = 1'b0;

        // Reset state, with input activity while reset is held
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_rgb   = 24'hFFFFFF;
        repeat (2) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        #2;
        reset = 1'b1;
        idle();

        // Flat field
        mode = 2'd1; threshold = 8'd1; cnt_target = 24'h000000; cnt_hits = 0;
        send_frame(8, 8, 0, 1'b0, 1'b1, -1);
        drain();
        expect_count("flat_zero", 64);

        // Vertical step: magnitude, binary, inverted
        mode = 2'd1; threshold = 8'h80; cnt_target = 24'hFFFFFF; cnt_hits = 0;
        send_frame(8, 8, 1, 1'b0, 1'b1, -1);
        drain();
        expect_count("step_mag", 12);

        mode = 2'd2; cnt_hits = 0;
        send_frame(8, 8, 1, 1'b0, 1'b1, -1);
        drain();
        expect_count("step_bin", 12);

        mode = 2'd3; cnt_target = 24'h000000; cnt_hits = 0;
        send_frame(8, 8, 1, 1'b1, 1'b1, -1);
        drain();
        expect_count("step_inv", 12);

        // Gray of pure red with random gaps
        mode = 2'd0; cnt_target = 24'h4C4C4C; cnt_hits = 0;
        send_frame(8, 8, 3, 1'b1, 1'b1, -1);
        drain();
        expect_count("gray_red", 49);

        // Random frames in every mode
        mode = 2'd1; threshold = 8'd60;
        send_frame(8, 8, 2, 1'b1, 1'b1, -1);
        drain();
        mode = 2'd2; threshold = 8'($urandom_range(1, 254));
        send_frame(8, 8, 2, 1'b1, 1'b1, -1);
        drain();

        // Short 5-pixel lines
        mode = 2'd1; threshold = 8'($urandom_range(1, 254));
        send_frame(8, 5, 2, 1'b1, 1'b1, -1);
        drain();
        mode = 2'd0;
        send_frame(8, 5, 2, 1'b1, 1'b1, -1);
        drain();
        mode = 2'd3; threshold = 8'd0;
        send_frame(6, 5, 2, 1'b0, 1'b1, -1);
        drain();

        // Line overrun: no eol at all, rows wrap at COLS
        mode = 2'd1; threshold = 8'd100;
        send_frame(4, 14, 2, 1'b1, 1'b0, -1);
        drain();

        // One-pixel line (sof and eol together), then 2-pixel lines
        mode = 2'd0;
        step(1'b1, 24'($urandom), 1'b1, 1'b1);
        for (int r = 1; r < 4; r++) begin
            step(1'b1, 24'($urandom), 1'b0, 1'b0);
            step(1'b1, 24'($urandom), 1'b0, 1'b1);
        end
        drain();

        // Async reset during row 3, then a fresh frame
        mode = 2'd1; threshold = 8'd40;
        send_frame(8, 8, 2, 1'b0, 1'b1, 28);
        async_reset_mid();
        idle();
        idle();
        send_frame(8, 8, 2, 1'b1, 1'b1, -1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
